sec_tick_timekeeper: RTL and testbench
======================================

Name: sec_tick_timekeeper

Overview:
- Consumer end of the one-second square-wave clock used across the alarm clock design.
- Samples the slow `one_sec_clock` level in the `clk` domain and detects its rising edge, giving exactly one tick per second.
- Advances a 24-hour BCD time-of-day counter (hh:mm:ss) on each tick.
- Also accepts a time-set handshake and flags a missing or stalled one-second source via a watchdog.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `one_sec_clock`; minimum 2.
- TIMEOUT_CYCLES, 60000000, `clk` cycles allowed between detected rising edges before `tick_lost` asserts.
- CNT_W, 26, width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- one_sec_clock  input  1  one-second square wave; rising edge once per second.
- run  input  1  1 = count on ticks; 0 = ticks are ignored (time frozen).
- set_req  input  1  request to load the time from the set_* inputs.
- set_hh  input  8  BCD hours, 00-23.
- set_mm  input  8  BCD minutes, 00-59.
- set_ss  input  8  BCD seconds, 00-59.
- set_ack  output  1  one-cycle pulse: load accepted.
- set_err  output  1  one-cycle pulse: load rejected (invalid BCD or out of range).
- hours  output  8  BCD hours.
- minutes  output  8  BCD minutes.
- seconds  output  8  BCD seconds.
- sec_pulse  output  1  one-cycle pulse when time advances.
- day_wrap  output  1  one-cycle pulse on 23:59:59 -> 00:00:00.
- tick_lost  output  1  level; source missing or stalled.

Behaviour:
- Reset (rst_n low, asynchronous):
  - hours/minutes/seconds = 00:00:00.
  - set_ack, set_err, sec_pulse, day_wrap, tick_lost = 0.
  - Synchroniser flops and edge-history flop = 0; watchdog counter = 0.
- Synchroniser: `one_sec_clock` passes through SYNC_STAGES flops. The edge-history flop holds the previous synchronised value.
- Tick: synchronised value = 1 and history = 0. Only rising edges count; falling edges are ignored.
- Latency (SYNC_STAGES = 2): input rises before edge E0; the counters, `sec_pulse` and `day_wrap` update at edge E2.
- Counting on tick with run = 1:
  - seconds +1, BCD; each nibble wraps 9 -> 0 with carry.
  - seconds 59 -> 00 carries into minutes; minutes 59 -> 00 carries into hours; hours 23 -> 00.
  - `sec_pulse` = 1 for one cycle.
  - `day_wrap` = 1 for one cycle when 23:59:59 -> 00:00:00.
- Tick with run = 0: no count change, no pulses. The watchdog still restarts.
- Set handshake:
  - set_req is sampled each cycle. On a cycle with set_req = 1, and only on its rising edge (set_req = 1, previous set_req = 0), the inputs are validated:
    - every nibble must be 0-9;
    - hh <= 0x23, mm <= 0x59, ss <= 0x59.
  - Valid: load all three fields at the next edge; `set_ack` = 1 for one cycle.
  - Invalid: time unchanged; `set_err` = 1 for one cycle.
  - Holding set_req high produces exactly one ack or err.
- Simultaneous set and tick: the set wins. The loaded value is exact, the tick is discarded, and `sec_pulse`/`day_wrap` stay 0.
- Watchdog:
  - Counter clears on every detected tick and on reset. Otherwise it increments, saturating at TIMEOUT_CYCLES.
  - `tick_lost` = 1 while counter == TIMEOUT_CYCLES. It clears on the cycle after the next tick.
  - `tick_lost` does not stop counting.
- Reset mid-operation: all state returns to reset values immediately. The first tick after release is the first rising edge seen by the synchroniser. A level that is already 1 at release produces one tick after SYNC_STAGES cycles.

Decomposition:
- Shared package `clock_pkg`:
  - BCD field width (8).
  - Limits MAX_HH = 8'h23, MAX_MM = MAX_SS = 8'h59.
  - Typedef `bcd_time_t` struct {hh, mm, ss}.
- Sub-module `bcd_mod_counter`:
  - Parameterised by max BCD value.
  - Inputs: inc, load, load value.
  - Outputs: value, carry-out.
  - Instantiated three times, with carries chained.
- The synchroniser, edge detector and watchdog stay in the top module.

Test Plan:
- Reset -> outputs 00:00:00, all pulses 0, tick_lost 0. Drive one rising edge on `one_sec_clock` -> at E2 seconds = 0x01 and sec_pulse high for exactly one cycle.
- Set 23:59:59 (valid) -> set_ack one pulse, time loaded. One tick -> 00:00:00, day_wrap and sec_pulse each one cycle.
- Set 09:59:59, then a tick -> 10:00:00 (BCD nibble carry across all fields). Set hh = 0x24 -> set_err, time unchanged. Set mm = 0x5A -> set_err.
- set_req rising on the exact cycle a tick is detected with time 12:00:00, loading 05:06:07 -> time = 05:06:07, no sec_pulse; the next tick gives 05:06:08.
- Use TIMEOUT_CYCLES = 100 and hold the input low for 150 cycles -> tick_lost rises at cycle 100 and stays. Then give one edge -> tick_lost clears and the count advances.
- run = 0 over 3 ticks -> time frozen, no pulses. Assert rst_n low mid-count at 00:00:42 -> immediately 00:00:00 with all flags 0.

Source files
------------

// File: rtl/clock_pkg.sv
//==============================================================================
// Module : clock_pkg
// Brief  : Shared BCD time-of-day types, limits and range check.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package clock_pkg;

    localparam int BCD_W = 8;

    localparam logic [BCD_W-1:0] MAX_HH = 8'h23;
    localparam logic [BCD_W-1:0] MAX_MM = 8'h59;
    localparam logic [BCD_W-1:0] MAX_SS = 8'h59;

    typedef struct packed {
        logic [BCD_W-1:0] hh;
        logic [BCD_W-1:0] mm;
        logic [BCD_W-1:0] ss;
    } bcd_time_t;

    // Nibble check is needed separately: 8'h1A passes a plain <= 8'h23 test.
    function automatic logic bcd_in_range(input logic [BCD_W-1:0] v,
                                          input logic [BCD_W-1:0] max_v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_mod_counter.sv
//==============================================================================
// Module : bcd_mod_counter
// Brief  : Two-digit BCD counter wrapping at MAX_VAL, with load and carry-out.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX_VAL = 8'h59
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_load,
    input  logic [BCD_W-1:0] i_load_val,
    output logic [BCD_W-1:0] o_value,
    output logic             o_carry
);

    logic [BCD_W-1:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (i_inc) begin
            if (r_value == MAX_VAL) begin
                r_value <= '0;
            end else if (r_value[3:0] == 4'd9) begin
                r_value <= {r_value[7:4] + 4'd1, 4'd0};
            end else begin
                r_value <= r_value + 8'd1;
            end
        end
    end

    assign o_value = r_value;
    assign o_carry = i_inc && (r_value == MAX_VAL);

endmodule

`default_nettype wire

// File: rtl/sec_tick_timekeeper.sv
//==============================================================================
// Module : sec_tick_timekeeper
// Brief  : Syncs the 1 Hz source, counts BCD hh:mm:ss, handles time-set, watchdog.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module sec_tick_timekeeper
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 60000000,
    parameter int CNT_W          = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_one_sec_clock,
    input  logic             i_run,
    input  logic             i_set_req,
    input  logic [BCD_W-1:0] i_set_hh,
    input  logic [BCD_W-1:0] i_set_mm,
    input  logic [BCD_W-1:0] i_set_ss,
    output logic             o_set_ack,
    output logic             o_set_err,
    output logic [BCD_W-1:0] o_hours,
    output logic [BCD_W-1:0] o_minutes,
    output logic [BCD_W-1:0] o_seconds,
    output logic             o_sec_pulse,
    output logic             o_day_wrap,
    output logic             o_tick_lost
);

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   r_set_req_d;
    logic [CNT_W-1:0]       r_wd_cnt;
    logic                   r_set_ack;
    logic                   r_set_err;
    logic                   r_sec_pulse;
    logic                   r_day_wrap;

    logic      w_synced;
    logic      w_tick;
    logic      w_set_rise;
    logic      w_set_ok;
    logic      w_load;
    logic      w_inc;
    logic      w_c_ss;
    logic      w_c_mm;
    logic      w_c_hh;
    bcd_time_t w_set_time;

    assign w_synced   = r_sync[SYNC_STAGES-1];
    assign w_tick     = w_synced && !r_hist;
    assign w_set_rise = i_set_req && !r_set_req_d;
    assign w_set_time = '{hh: i_set_hh, mm: i_set_mm, ss: i_set_ss};
    assign w_set_ok   = bcd_in_range(w_set_time.hh, MAX_HH) &&
                        bcd_in_range(w_set_time.mm, MAX_MM) &&
                        bcd_in_range(w_set_time.ss, MAX_SS);
    assign w_load     = w_set_rise && w_set_ok;
    // An accepted load in the same cycle as a tick swallows the tick.
    assign w_inc      = w_tick && i_run && !w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync      <= '0;
            r_hist      <= 1'b0;
            r_set_req_d <= 1'b0;
            r_wd_cnt    <= '0;
            r_set_ack   <= 1'b0;
            r_set_err   <= 1'b0;
            r_sec_pulse <= 1'b0;
            r_day_wrap  <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], i_one_sec_clock};
            r_hist      <= w_synced;
            r_set_req_d <= i_set_req;
            r_set_ack   <= w_load;
            r_set_err   <= w_set_rise && !w_set_ok;
            r_sec_pulse <= w_inc;
            r_day_wrap  <= w_c_hh;
            if (w_tick) begin
                r_wd_cnt <= '0;
            end else if (r_wd_cnt != c_TIMEOUT) begin
                r_wd_cnt <= r_wd_cnt + CNT_W'(1);
            end
        end
    end

    bcd_mod_counter #(.MAX_VAL(MAX_SS)) u_ss (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (w_inc),
        .i_load     (w_load),
        .i_load_val (w_set_time.ss),
        .o_value    (o_seconds),
        .o_carry    (w_c_ss)
    );

    bcd_mod_counter #(.MAX_VAL(MAX_MM)) u_mm (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (w_c_ss),
        .i_load     (w_load),
        .i_load_val (w_set_time.mm),
        .o_value    (o_minutes),
        .o_carry    (w_c_mm)
    );

    bcd_mod_counter #(.MAX_VAL(MAX_HH)) u_hh (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (w_c_mm),
        .i_load     (w_load),
        .i_load_val (w_set_time.hh),
        .o_value    (o_hours),
        .o_carry    (w_c_hh)
    );

    assign o_set_ack   = r_set_ack;
    assign o_set_err   = r_set_err;
    assign o_sec_pulse = r_sec_pulse;
    assign o_day_wrap  = r_day_wrap;
    assign o_tick_lost = (r_wd_cnt == c_TIMEOUT);

endmodule

`default_nettype wire

// File: tb/tb_sec_tick_timekeeper.sv
//==============================================================================
// Module : tb_sec_tick_timekeeper
// Brief  : Self-checking bench with a seconds-of-day reference model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_sec_tick_timekeeper;

    localparam int T = 100;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       d_oc  = 1'b0;
    logic       d_run = 1'b1;
    logic       d_sr  = 1'b0;
    logic [7:0] d_hh  = 8'h00;
    logic [7:0] d_mm  = 8'h00;
    logic [7:0] d_ss  = 8'h00;

    logic       o_set_ack, o_set_err, o_sec_pulse, o_day_wrap, o_tick_lost;
    logic [7:0] o_hours, o_minutes, o_seconds;

    sec_tick_timekeeper #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (26)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_one_sec_clock (d_oc),
        .i_run           (d_run),
        .i_set_req       (d_sr),
        .i_set_hh        (d_hh),
        .i_set_mm        (d_mm),
        .i_set_ss        (d_ss),
        .o_set_ack       (o_set_ack),
        .o_set_err       (o_set_err),
        .o_hours         (o_hours),
        .o_minutes       (o_minutes),
        .o_seconds       (o_seconds),
        .o_sec_pulse     (o_sec_pulse),
        .o_day_wrap      (o_day_wrap),
        .o_tick_lost     (o_tick_lost)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: time as plain seconds-of-day, input history by edge.
    int m_t;
    int m_cnt;
    bit m_h1, m_h2, m_h3, m_srp;
    bit m_ack, m_err, m_pulse, m_wrap;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int bcd_dec(input logic [7:0] v);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return -1;
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    task automatic model_reset();
        m_t = 0; m_cnt = 0;
        m_h1 = 0; m_h2 = 0; m_h3 = 0; m_srp = 0;
        m_ack = 0; m_err = 0; m_pulse = 0; m_wrap = 0;
    endtask

    task automatic model_edge();
        bit tick, rise, ok;
        int h, mi, s;
        tick = m_h2 && !m_h3;
        rise = d_sr && !m_srp;
        h  = bcd_dec(d_hh);
        mi = bcd_dec(d_mm);
        s  = bcd_dec(d_ss);
        ok = rise && h >= 0 && h <= 23 && mi >= 0 && mi <= 59 && s >= 0 && s <= 59;
        m_ack = ok; m_err = rise && !ok; m_pulse = 0; m_wrap = 0;
        if (ok) begin
            m_t = h * 3600 + mi * 60 + s;
        end else if (tick && d_run) begin
            m_t = (m_t + 1) % 86400;
            m_pulse = 1;
            m_wrap = (m_t == 0);
        end
        if (tick) m_cnt = 0;
        else if (m_cnt < T) m_cnt++;
        m_h3 = m_h2; m_h2 = m_h1; m_h1 = d_oc; m_srp = d_sr;
    endtask

    task automatic compare(input string name);
        logic [28:0] act, exp_v;
        act   = {o_hours, o_minutes, o_seconds, o_set_ack, o_set_err,
                 o_sec_pulse, o_day_wrap, o_tick_lost};
        exp_v = {to_bcd(m_t / 3600), to_bcd((m_t / 60) % 60), to_bcd(m_t % 60),
                 m_ack, m_err, m_pulse, m_wrap, (m_cnt == T)};
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h required %h (hh_mm_ss_ack_err_pulse_wrap_lost)",
                     name, act, exp_v);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp_v);
        end
    endtask

    task automatic step(input string name);
        @(posedge clk);
        #1;
        model_edge();
        compare(name);
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare(name);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic apply_set(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
        d_hh = hh; d_mm = mm; d_ss = ss; d_sr = 1'b1;
        step("set");
        d_sr = 1'b0;
        step("set_rel");
    endtask

    // Rising edge applied before E0; update visible after E2.
    task automatic tick_chk(input string name, input logic [23:0] exp_t,
                            input bit exp_pulse, input bit exp_wrap);
        d_oc = 1'b1;
        step(name); step(name); step(name);
        chk({name, "_time"}, {8'h0, o_hours, o_minutes, o_seconds}, {8'h0, exp_t});
        chk({name, "_pw"}, {30'h0, o_sec_pulse, o_day_wrap}, {30'h0, exp_pulse, exp_wrap});
        d_oc = 1'b0;
        step(name);
        chk({name, "_pw_end"}, {30'h0, o_sec_pulse, o_day_wrap}, 32'h0);
        step(name);
    endtask

    typedef struct {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        bit         ok;
    } set_vec_t;

    set_vec_t tbl[9];

    initial begin
        logic [23:0] exp_time;
        int          hold;

        tbl[0] = '{8'h23, 8'h59, 8'h59, 1'b1};
        tbl[1] = '{8'h09, 8'h59, 8'h59, 1'b1};
        tbl[2] = '{8'h24, 8'h00, 8'h00, 1'b0};
        tbl[3] = '{8'h12, 8'h5A, 8'h00, 1'b0};
        tbl[4] = '{8'h00, 8'h00, 8'h5A, 1'b0};
        tbl[5] = '{8'h1A, 8'h00, 8'h00, 1'b0};
        tbl[6] = '{8'h00, 8'h60, 8'h00, 1'b0};
        tbl[7] = '{8'h19, 8'h45, 8'h33, 1'b1};
        tbl[8] = '{8'h00, 8'h00, 8'h00, 1'b1};

        model_reset();
        @(posedge clk);
        #1;
        compare("reset");
        chk("reset_out", {o_hours, o_minutes, o_seconds, o_set_ack, o_set_err,
                          o_sec_pulse, o_day_wrap, o_tick_lost}, 32'h0);
        rst_n = 1'b1;

        tick_chk("first_tick", 24'h000001, 1'b1, 1'b0);

        exp_time = 24'h000001;
        for (int i = 0; i < 9; i++) begin
            d_hh = tbl[i].hh; d_mm = tbl[i].mm; d_ss = tbl[i].ss; d_sr = 1'b1;
            step("tbl_set");
            chk("tbl_ack_err", {30'h0, o_set_ack, o_set_err},
                tbl[i].ok ? 32'h2 : 32'h1);
            if (tbl[i].ok) exp_time = {tbl[i].hh, tbl[i].mm, tbl[i].ss};
            chk("tbl_time", {8'h0, o_hours, o_minutes, o_seconds}, {8'h0, exp_time});
            step("tbl_hold");
            chk("tbl_hold_once", {30'h0, o_set_ack, o_set_err}, 32'h0);
            d_sr = 1'b0;
            step("tbl_rel");
        end

        apply_set(8'h23, 8'h59, 8'h59);
        tick_chk("day_wrap", 24'h000000, 1'b1, 1'b1);
        apply_set(8'h09, 8'h59, 8'h59);
        tick_chk("bcd_carry", 24'h100000, 1'b1, 1'b0);

        apply_set(8'h12, 8'h00, 8'h00);
        d_oc = 1'b1;
        step("sim_a"); step("sim_b");
        d_hh = 8'h05; d_mm = 8'h06; d_ss = 8'h07; d_sr = 1'b1;
        step("sim_set");
        chk("sim_time", {8'h0, o_hours, o_minutes, o_seconds}, 32'h050607);
        chk("sim_pulse", {30'h0, o_sec_pulse, o_set_ack}, 32'h1);
        d_sr = 1'b0; d_oc = 1'b0;
        step("sim_c"); step("sim_d");
        tick_chk("sim_next", 24'h050608, 1'b1, 1'b0);

        d_run = 1'b0;
        for (int i = 0; i < 3; i++) tick_chk("frozen", 24'h050608, 1'b0, 1'b0);
        d_run = 1'b1;

        do_reset("wd_reset");
        d_oc = 1'b0;
        for (int i = 1; i <= 150; i++) begin
            step("wd");
            if (i == 99)  chk("wd_99",  {31'h0, o_tick_lost}, 32'h0);
            if (i == 100) chk("wd_100", {31'h0, o_tick_lost}, 32'h1);
            if (i == 150) chk("wd_150", {31'h0, o_tick_lost}, 32'h1);
        end
        tick_chk("wd_recover", 24'h000001, 1'b1, 1'b0);
        chk("wd_cleared", {31'h0, o_tick_lost}, 32'h0);

        apply_set(8'h00, 8'h00, 8'h41);
        tick_chk("pre_rst", 24'h000042, 1'b1, 1'b0);
        d_oc = 1'b1;
        step("mid_hi");
        do_reset("mid_reset");
        chk("mid_reset_out", {o_hours, o_minutes, o_seconds, o_set_ack, o_set_err,
                              o_sec_pulse, o_day_wrap, o_tick_lost}, 32'h0);
        step("rel_a"); step("rel_b"); step("rel_c");
        chk("level_at_release", {24'h0, o_seconds}, 32'h01);
        d_oc = 1'b0;
        step("rel_d"); step("rel_e");

        hold = 5;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                d_oc = ~d_oc;
                hold = ($urandom_range(0, 14) == 0) ? 130 : int'($urandom_range(3, 40));
            end else begin
                hold--;
            end
            d_run = ($urandom_range(0, 9) != 0);
            if (d_sr) begin
                d_sr = ($urandom_range(0, 1) == 0);
            end else if ($urandom_range(0, 19) == 0) begin
                d_sr = 1'b1;
                if ($urandom_range(0, 1) == 0) begin
                    d_hh = to_bcd(int'($urandom_range(0, 23)));
                    d_mm = to_bcd(int'($urandom_range(0, 59)));
                    d_ss = to_bcd(int'($urandom_range(0, 59)));
                end else begin
                    d_hh = 8'($urandom); d_mm = 8'($urandom); d_ss = 8'($urandom);
                end
            end
            if ($urandom_range(0, 799) == 0) do_reset("rand_reset");
            else step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
